// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci ROM arbiter slice.
package fib_pkg;

  localparam int unsigned NREQ       = 2;
  localparam int unsigned FIB_ADDR_W = 4;
  localparam int unsigned FIB_DATA_W = 6;
  localparam int unsigned FIB_DEPTH  = 10;

  typedef logic [FIB_ADDR_W-1:0] fib_addr_t;
  typedef logic [FIB_DATA_W-1:0] fib_data_t;

  typedef enum logic {PRI0, PRI1} fib_pri_e;

  function automatic logic addr_in_range(input fib_addr_t a);
    return a < fib_addr_t'(FIB_DEPTH);
  endfunction

endpackage

// File: rtl/fib_rr_arb2.sv
// Two-way round-robin arbiter; owns the priority pointer, grants are combinational.
module fib_rr_arb2
  import fib_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] elig,
  input  logic       accept,
  output logic [1:0] grant
);

  fib_pri_e pri;
  fib_pri_e pri_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri <= PRI0;
    else        pri <= pri_next;
  end

  always_comb begin
    pri_next = pri;
    if (accept) pri_next = grant[0] ? PRI1 : PRI0;
  end

  always_comb begin
    grant = '0;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (pri == PRI0) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/fibonnacci.sv
// Combinational 10-entry Fibonacci ROM; indices 10-15 read as 0.
module fibonnacci
  import fib_pkg::*;
(
  input  logic [FIB_ADDR_W-1:0] a,
  output logic [FIB_DATA_W-1:0] number
);

  always_comb begin
    number = '0;
    case (a)
      4'd0: number = 6'd0;
      4'd1: number = 6'd1;
      4'd2: number = 6'd1;
      4'd3: number = 6'd2;
      4'd4: number = 6'd3;
      4'd5: number = 6'd5;
      4'd6: number = 6'd8;
      4'd7: number = 6'd13;
      4'd8: number = 6'd21;
      4'd9: number = 6'd34;
      default: number = '0;
    endcase
  end

endmodule

// File: rtl/fib_rom_arbiter.sv
// Shares one Fibonacci ROM read port between two requesters with one-entry response buffers.
// Optional range checking is enabled by defining FIB_ROM_ADDR_CHECK_EN.
module fib_rom_arbiter
  import fib_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [FIB_ADDR_W-1:0] req_addr0,
  input  logic [FIB_ADDR_W-1:0] req_addr1,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [FIB_DATA_W-1:0] rsp_data0,
  output logic [FIB_DATA_W-1:0] rsp_data1,
  output logic [1:0]            rsp_err,
  input  logic [1:0]            rsp_ready,
  output logic [FIB_ADDR_W-1:0] rom_addr,
  input  logic [FIB_DATA_W-1:0] rom_data
);

  logic [1:0] elig;
  logic [1:0] grant;
  logic       accept;
  fib_addr_t  sel_addr;
  fib_data_t  ld_data;
  logic       ld_err;

  fib_data_t  data_q [NREQ];
  logic [1:0] valid_q;
  logic [1:0] err_q;

  // rst_n gating keeps req_ready low for the whole reset interval
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      elig[i] = rst_n & req_valid[i] & (~valid_q[i] | rsp_ready[i]);
  end

  fib_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .elig   (elig),
    .accept (accept),
    .grant  (grant)
  );

  assign accept    = |grant;
  assign req_ready = grant;
  assign sel_addr  = grant[1] ? req_addr1 : req_addr0;

`ifdef FIB_ROM_ADDR_CHECK_EN
  logic oor;
  always_comb begin
    oor      = ~addr_in_range(sel_addr);
    rom_addr = (accept && !oor) ? sel_addr : '0;
    ld_data  = oor ? '0 : rom_data;
    ld_err   = oor;
  end
`else
  always_comb begin
    rom_addr = accept ? sel_addr : '0;
    ld_data  = rom_data;
    ld_err   = 1'b0;
  end
`endif

  // A load wins over a drain, so simultaneous drain+accept keeps valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < NREQ; i++) data_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= ld_data;
          err_q[i]   <= ld_err;
        end else if (valid_q[i] && rsp_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_data0 = data_q[0];
  assign rsp_data1 = data_q[1];

endmodule

// File: tb/tb_fib_rom_arbiter.sv
// Scoreboard bench for fib_rom_arbiter driving the real fibonnacci ROM.
module tb_fib_rom_arbiter;
  import fib_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_addr0, req_addr1;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [5:0] rsp_data0, rsp_data1;
  logic [1:0] rsp_err;
  logic [1:0] rsp_ready;
  logic [3:0] rom_addr;
  logic [5:0] rom_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] data;
    logic       err;
    bit         chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  fib_rom_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data0 (rsp_data0),
    .rsp_data1 (rsp_data1),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  fibonnacci u_rom (
    .a      (rom_addr),
    .number (rom_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t expect_for(input logic [3:0] a);
    logic [5:0] tbl [10];
    exp_t e;
    tbl = '{6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34};
    if (a < 4'd10) begin
      e.data = tbl[a];
      e.err  = 1'b0;
      e.chk  = 1'b1;
    end else begin
`ifdef FIB_ROM_ADDR_CHECK_EN
      e.data = '0;
      e.err  = 1'b1;
      e.chk  = 1'b1;
`else
      e.data = '0;
      e.err  = 1'b0;
      e.chk  = 1'b0;
`endif
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: every observed accept pushes its expected response
  always @(negedge clk) begin
    if (req_valid[0] && req_ready[0]) q0.push_back(expect_for(req_addr0));
    if (req_valid[1] && req_ready[1]) q1.push_back(expect_for(req_addr1));
  end

  // Monitor: a response consumed at the coming edge is popped and compared
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("rsp0_err", {31'd0, rsp_err[0]}, {31'd0, e.err});
        if (e.chk) check("rsp0_data", {26'd0, rsp_data0}, {26'd0, e.data});
      end
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rsp1_err", {31'd0, rsp_err[1]}, {31'd0, e.err});
        if (e.chk) check("rsp1_data", {26'd0, rsp_data1}, {26'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_g;

    rst_n = 1'b0; req_valid = 2'b11; req_addr0 = 4'd3; req_addr1 = 4'd3; rsp_ready = 2'b00;
    #2;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    check("rst_rsp_data0", {26'd0, rsp_data0}, 32'd0);
    check("rst_rsp_data1", {26'd0, rsp_data1}, 32'd0);
    check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    check("rst_pri", {31'd0, dut.u_arb.pri}, {31'd0, PRI0});
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    samp();
    check("idle_req_ready", {30'd0, req_ready}, 32'd0);

    // requester 0 alone, addr 7
    tick(); req_valid = 2'b01; req_addr0 = 4'd7; rsp_ready = 2'b11;
    samp();
    check("r0_req_ready", {30'd0, req_ready}, 32'd1);
    check("r0_rom_addr", {28'd0, rom_addr}, 32'd7);
    tick(); req_valid = 2'b00;
    samp();
    check("r0_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("r0_rsp_data0", {26'd0, rsp_data0}, 32'd13);

    // both saturated: pointer is PRI1 after granting 0, so 1 wins first
    exp_g = 2'b10;
    req_addr0 = 4'd4; req_addr1 = 4'd9;
    for (int k = 0; k < 20; k++) begin
      tick(); req_valid = 2'b11;
      samp();
      check("sat_grant", {30'd0, req_ready}, {30'd0, exp_g});
      check("sat_rom_addr", {28'd0, rom_addr}, exp_g[0] ? 32'd4 : 32'd9);
      exp_g = ~exp_g;
    end
    tick(); req_valid = 2'b00;
    samp();

    // backpressure on requester 1, then drain and accept together
    tick(); req_valid = 2'b10; req_addr1 = 4'd5; rsp_ready = 2'b01;
    samp();
    check("bp_first_grant", {30'd0, req_ready}, 32'd2);
    for (int k = 0; k < 2; k++) begin
      tick(); req_addr1 = 4'd6;
      samp();
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      check("bp_hold_data1", {26'd0, rsp_data1}, 32'd5);
    end
    tick(); rsp_ready = 2'b11;
    samp();
    check("drain_acc_grant", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    samp();
    check("drain_acc_valid1", {31'd0, rsp_valid[1]}, 32'd1);
    check("drain_acc_data1", {26'd0, rsp_data1}, 32'd8);

    // out-of-range address
    tick(); req_valid = 2'b01; req_addr0 = 4'd12;
    samp();
    check("oor_grant", {30'd0, req_ready}, 32'd1);
`ifdef FIB_ROM_ADDR_CHECK_EN
    check("oor_rom_addr", {28'd0, rom_addr}, 32'd0);
`else
    check("oor_rom_addr", {28'd0, rom_addr}, 32'd12);
`endif
    tick(); req_valid = 2'b00;
    samp();
`ifdef FIB_ROM_ADDR_CHECK_EN
    check("oor_rsp_err", {30'd0, rsp_err}, 32'd1);
    check("oor_rsp_data0", {26'd0, rsp_data0}, 32'd0);
`else
    check("oor_rsp_err", {30'd0, rsp_err}, 32'd0);
`endif

    // fill both buffers, then reset asynchronously mid-cycle
    tick(); rsp_ready = 2'b00; req_valid = 2'b11; req_addr0 = 4'd2; req_addr1 = 4'd3;
    samp();
    check("fill_grant_a", {30'd0, req_ready}, 32'd2);
    tick();
    samp();
    check("fill_grant_b", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    samp();
    check("fill_rsp_valid", {30'd0, rsp_valid}, 32'd3);
    check("fill_data0", {26'd0, rsp_data0}, 32'd1);
    check("fill_data1", {26'd0, rsp_data1}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("arst_rsp_data0", {26'd0, rsp_data0}, 32'd0);
    check("arst_rsp_data1", {26'd0, rsp_data1}, 32'd0);
    check("arst_pri", {31'd0, dut.u_arb.pri}, {31'd0, PRI0});
    q0.delete();
    q1.delete();
    tick();
    rst_n = 1'b1; req_valid = 2'b11; req_addr0 = 4'd1; req_addr1 = 4'd8; rsp_ready = 2'b11;
    samp();
    check("post_rst_grant0", {30'd0, req_ready}, 32'd1);
    tick();
    samp();
    check("post_rst_grant1", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      samp();
      tick();
    end
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
